// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: ramMode decoding, FSM states,
// memory command payload and lane helpers.
package lsu_mem_ctrl_pkg;

  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned BEW       = 4;
  localparam int unsigned MODE_W    = 4;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned STORE_BIT = 0;

  localparam logic [F3_W-1:0] MEM_B  = 3'b000;
  localparam logic [F3_W-1:0] MEM_H  = 3'b001;
  localparam logic [F3_W-1:0] MEM_W  = 3'b010;
  localparam logic [F3_W-1:0] MEM_BU = 3'b100;
  localparam logic [F3_W-1:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
  } mem_cmd_t;

  // Unsigned loads have no store counterpart; everything else is illegal.
  function automatic logic mode_legal(input logic [MODE_W-1:0] mode);
    logic store;
    store = mode[STORE_BIT];
    case (mode[MODE_W-1:1])
      MEM_B, MEM_H, MEM_W: mode_legal = 1'b1;
      MEM_BU, MEM_HU:      mode_legal = !store;
      default:             mode_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [F3_W-1:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [BEW-1:0] be_for(input logic [F3_W-1:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   be_for = 4'b0001 << lane;
      2'b01:   be_for = 4'b0011 << {lane[1], 1'b0};
      default: be_for = 4'b1111;
    endcase
  endfunction

  function automatic logic [DW-1:0] wdata_rep(input logic [F3_W-1:0] f3, input logic [DW-1:0] wd);
    case (f3[1:0])
      2'b00:   wdata_rep = {4{wd[7:0]}};
      2'b01:   wdata_rep = {2{wd[15:0]}};
      default: wdata_rep = wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface lsu_mem_ctrl_if;
  import lsu_mem_ctrl_pkg::*;

  logic           mem_req;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [BEW-1:0] mem_be;
  logic [DW-1:0]  mem_wdata;
  logic           mem_ready;
  logic [DW-1:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction and sign/zero extension of a read word.
module lsu_load_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [DW-1:0]   word,
  input  logic [1:0]      lane,
  input  logic [F3_W-1:0] funct3,
  output logic [DW-1:0]   result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b  = 8'(word >> {lane, 3'b000});
    sel_h  = lane[1] ? word[31:16] : word[15:0];
    result = word;
    case (funct3)
      MEM_B:   result = {{24{sel_b[7]}}, sel_b};
      MEM_BU:  result = {24'd0, sel_b};
      MEM_H:   result = {{16{sel_h[15]}}, sel_h};
      MEM_HU:  result = {16'd0, sel_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one data-memory transaction per accepted start, with
// alignment/legality checks, timeout, and extended load writeback data.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] ramMode,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DW-1:0]     rdata,
  lsu_mem_ctrl_if.master    mem
);

  state_e            state_q, state_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              req_q, req_d;
  logic              busy_d, done_d, err_d;
  logic [DW-1:0]     rdata_d;
  logic [F3_W-1:0]   f3_q;
  logic              store_q;
  logic [1:0]        lane_q;
  logic [TO_W-1:0]   cnt_q;
  logic              start_ok;
  logic              timeout_hit;
  logic [DW-1:0]     load_ext;

  assign start_ok    = mode_legal(ramMode) && !misaligned(ramMode[MODE_W-1:1], addr[1:0]);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

  lsu_load_align u_align (
    .word   (mem.mem_rdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .result (load_ext)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a ready response wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = start_ok ? ST_REQ : ST_ERR;
      ST_REQ: begin
        if (mem.mem_ready)    state_d = ST_RESP;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    cmd_d   = cmd_q;
    req_d   = (state_d == ST_REQ);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_RESP) || (state_d == ST_ERR);
    err_d   = (state_d == ST_ERR);
    rdata_d = rdata;
    if (state_q == ST_IDLE && state_d == ST_REQ) begin
      cmd_d.we    = ramMode[STORE_BIT];
      cmd_d.addr  = {addr[AW-1:2], 2'b00};
      cmd_d.be    = be_for(ramMode[MODE_W-1:1], addr[1:0]);
      cmd_d.wdata = wdata_rep(ramMode[MODE_W-1:1], wdata);
    end else if (state_d != ST_REQ) begin
      cmd_d = '0;
    end
    if (state_q == ST_REQ && mem.mem_ready && !store_q) rdata_d = load_ext;
  end

  // Output and capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q   <= '0;
      req_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      lane_q  <= '0;
      cnt_q   <= '0;
    end else begin
      cmd_q <= cmd_d;
      req_q <= req_d;
      busy  <= busy_d;
      done  <= done_d;
      err   <= err_d;
      rdata <= rdata_d;
      if (state_q == ST_IDLE && start) begin
        f3_q    <= ramMode[MODE_W-1:1];
        store_q <= ramMode[STORE_BIT];
        lane_q  <= addr[1:0];
      end
      if (state_q != ST_REQ)    cnt_q <= '0;
      else if (!mem.mem_ready)  cnt_q <= cnt_q + TO_W'(1);
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = cmd_q.we;
  assign mem.mem_addr  = cmd_q.addr;
  assign mem.mem_be    = cmd_q.be;
  assign mem.mem_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl (built with TIMEOUT=4).
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ramMode = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err;
  logic [31:0] rdata;
  int          total = 0;
  int          bad = 0;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ramMode (ramMode),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rdata   (rdata),
    .mem     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] wd);
    start = 1'b1; ramMode = mode; addr = a; wdata = wd;
    step();
    start = 1'b0; ramMode = 4'hF; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    rst = 1'b1;
    step(); step();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", bus.mem_req); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    total++; if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 69'd0) begin bad++; $display("FAIL reset_bus got=%h exp=0", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lb();
    issue(4'b0000, 32'h0000_0103, 32'd0);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL lb_req got=%0h exp=1", bus.mem_req); end
    total++; if (bus.mem_be !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b exp=1000", bus.mem_be); end
    total++; if (bus.mem_addr !== 32'h0000_0100) begin bad++; $display("FAIL lb_addr got=%h exp=00000100", bus.mem_addr); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL lb_we got=%0h exp=0", bus.mem_we); end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h80FF_1234;
    step();
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL lb_done got=%b exp=10", {done, err}); end
    total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL lb_req_fall got=%0h exp=0", bus.mem_req); end
    step();
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL lb_idle got=%b exp=00", {busy, done}); end
  endtask

  task automatic test_lhu_wait();
    issue(4'b1010, 32'h0000_0202, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      total++; if ({bus.mem_req, busy, done} !== 3'b110) begin bad++; $display("FAIL lhu_hold_c%0d got=%b exp=110", c, {bus.mem_req, busy, done}); end
      total++; if ({bus.mem_be, bus.mem_addr} !== {4'b1100, 32'h0000_0200}) begin bad++; $display("FAIL lhu_bus_c%0d got=%h exp=%h", c, {bus.mem_be, bus.mem_addr}, {4'b1100, 32'h0000_0200}); end
      if (c == 4) begin bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBEEF_0000; end
      step();
    end
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    total++; if ({done, err, busy} !== 3'b101) begin bad++; $display("FAIL lhu_done got=%b exp=101", {done, err, busy}); end
    total++; if (rdata !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_rdata got=%h exp=0000beef", rdata); end
    step();
  endtask

  task automatic test_sh();
    issue(4'b0011, 32'h0000_0306, 32'h1234_ABCD);
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b111100) begin bad++; $display("FAIL sh_ctl got=%b exp=111100", {bus.mem_req, bus.mem_we, bus.mem_be}); end
    total++; if (bus.mem_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", bus.mem_wdata); end
    total++; if (bus.mem_addr !== 32'h0000_0304) begin bad++; $display("FAIL sh_addr got=%h exp=00000304", bus.mem_addr); end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_1111;
    step();
    bus.mem_ready = 1'b0;
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL sh_done got=%b exp=10", {done, err}); end
    total++; if (rdata !== 32'h0000_BEEF) begin bad++; $display("FAIL sh_rdata_hold got=%h exp=0000beef", rdata); end
    step();
  endtask

  task automatic test_sb();
    issue(4'b0001, 32'h0000_0702, 32'h0000_00A5);
    total++; if ({bus.mem_be, bus.mem_wdata} !== {4'b0100, 32'hA5A5_A5A5}) begin bad++; $display("FAIL sb_lane got=%h exp=%h", {bus.mem_be, bus.mem_wdata}, {4'b0100, 32'hA5A5_A5A5}); end
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    step();
  endtask

  task automatic test_errors();
    logic [3:0]  modes [2];
    logic [31:0] addrs [2];
    modes[0] = 4'b0101; addrs[0] = 32'h0000_0401;
    modes[1] = 4'b0111; addrs[1] = 32'h0000_0400;
    for (int i = 0; i < 2; i++) begin
      issue(modes[i], addrs[i], 32'hCAFE_F00D);
      total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL err%0d_req got=%0h exp=0", i, bus.mem_req); end
      total++; if ({done, err, busy} !== 3'b111) begin bad++; $display("FAIL err%0d_flags got=%b exp=111", i, {done, err, busy}); end
      total++; if (rdata !== 32'h0000_BEEF) begin bad++; $display("FAIL err%0d_rdata got=%h exp=0000beef", i, rdata); end
      step();
      total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL err%0d_idle got=%b exp=00", i, {done, busy}); end
    end
  endtask

  task automatic test_timeout();
    issue(4'b0100, 32'h0000_0500, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      total++; if ({bus.mem_req, done} !== 2'b10) begin bad++; $display("FAIL to_hold_c%0d got=%b exp=10", c, {bus.mem_req, done}); end
      step();
    end
    total++; if ({bus.mem_req, done, err} !== 3'b011) begin bad++; $display("FAIL to_err got=%b exp=011", {bus.mem_req, done, err}); end
    step();
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL to_idle got=%b exp=000", {busy, done, err}); end
  endtask

  task automatic test_back_to_back();
    int dones;
    issue(4'b0100, 32'h0000_0600, 32'd0);
    #1 rst = 1'b1;
    #1;
    total++; if ({bus.mem_req, busy, done} !== 3'b000) begin bad++; $display("FAIL rst_mid got=%b exp=000", {bus.mem_req, busy, done}); end
    rst = 1'b0;
    step();
    issue(4'b0100, 32'h0000_0600, 32'd0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    start = 1'b1; ramMode = 4'b0000; addr = 32'h0000_0000;
    step();
    start = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dones++;
      if (c == 0) begin
        total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", rdata); end
      end
      step();
    end
    total++; if (dones != 1) begin bad++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%0h exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu_wait();
    test_sh();
    test_sb();
    test_errors();
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit that sits directly downstream of the instruction decoder.
- Consumes the decoder's 4-bit ramMode, where bits [3:1] are funct3 and bit [0] is 1 for a store. Also consumes the ALU-computed effective address and the rs2 store data.
- Runs one data-memory transaction over a req/ready handshake and returns a byte-lane-extracted, sign/zero-extended load result for register writeback.
- Flags misaligned or illegal accesses and memory timeouts.

Parameters:
- TIMEOUT, 255: max cycles to wait for mem_ready once a request is issued. 0 disables the timeout.
- TO_W, 8: width of the timeout counter. Must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request from the core; ignored while busy=1
- ramMode  in  4  {funct3, isStore}
- addr  in  32  byte effective address
- wdata  in  32  store data (rs2)
- busy  out  1  transaction in flight
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned, illegal mode, or timeout
- rdata  out  32  extended load result
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write strobe
- mem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory accepts the request (write) or returns data (read) this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1

Behaviour:
- Reset: all outputs are 0 and state is IDLE. Reset is asynchronous, so an assertion mid-transaction drops mem_req and busy immediately and discards the transaction. No done pulse is produced.
- Capture: start=1 in IDLE registers ramMode, addr and wdata. All memory-side outputs are registered from this captured copy; core inputs may change after the start cycle.
- Legal modes:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other combination is illegal.
- Misalignment: halfword access with addr[0]=1, or word access with addr[1:0]!=0.
- FSM states: IDLE, REQ, RESP, ERR.
  - IDLE -> REQ on start with a legal, aligned access. mem_req=1 from the next cycle (cycle 1).
  - IDLE -> ERR on start with an illegal or misaligned access. No memory request is issued.
  - REQ: hold mem_req, mem_we, mem_addr, mem_be and mem_wdata stable until mem_ready=1.
  - REQ with mem_ready: register the extracted load data (loads only) and go to RESP. mem_req falls the following cycle.
  - REQ timeout: the counter counts REQ cycles without mem_ready. On reaching TIMEOUT, go to ERR and drop mem_req.
  - RESP: done=1, err=0. Next state is IDLE.
  - ERR: done=1, err=1. Next state is IDLE.
- Best-case latency: start in cycle 0, mem_req in cycle 1, mem_ready in cycle 1, done in cycle 2.
- busy=1 in REQ, RESP and ERR. start is accepted again in the cycle after done (back in IDLE).
- mem_be:
  - SB/LB/LBU: 4'b0001 << addr[1:0].
  - SH/LH/LHU: 4'b0011 << {addr[1], 1'b0}.
  - SW/LW: 4'b1111.
- mem_wdata: SB replicates {4{wdata[7:0]}}, SH replicates {2{wdata[15:0]}}, SW passes wdata through.
- Load extraction: the byte lane is selected by addr[1:0] and the halfword by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- rdata updates only on a successful load. It holds its value across stores and error completions.
- mem_ready outside REQ is ignored.
- start while busy is dropped. It is neither queued nor flagged.

Decomposition:
- Shared package holds:
  - ramMode funct3 constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and the store-bit index.
  - FSM state encodings.
- One natural sub-module, lsu_load_align: purely combinational mem_rdata + addr[1:0] + funct3 -> extended 32-bit result. It is reused by any future cache path.
- Byte-enable and write-data replication stay inline.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF1234, mem_ready asserted with the request: mem_be=4'b1000, mem_addr=0x100, done in cycle 2, rdata=0xFFFFFF80, err=0.
- LHU at 0x202, mem_rdata=0xBEEF0000, mem_ready delayed 3 cycles: mem_req held for 4 cycles with stable outputs, rdata=0x0000BEEF, busy=1 throughout.
- SH at 0x306, wdata=0x1234ABCD: mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD; rdata unchanged after done.
- SW at 0x401, and ramMode=4'b0111 at 0x400: no mem_req in either case; done with err=1 one cycle after start.
- mem_ready never asserted with TIMEOUT=4: mem_req high for 4 cycles, then done and err=1; IDLE on the next cycle.
- rst pulsed while in REQ: mem_req, busy and done fall immediately; a following LW completes normally. A start issued while busy produces exactly one done.
